// File: rtl/gfx_pkg.sv
// Shared graphics types and default screen geometry for the raster fill path.
package gfx_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a fill rectangle against the visible screen.
// The bottom-right corner is clamped on screen, and an empty rectangle is flagged.
module rect_clip #(
  parameter int H_RES   = gfx_pkg::H_RES_DEF,
  parameter int V_RES   = gfx_pkg::V_RES_DEF,
  parameter int COORD_W = gfx_pkg::COORD_W_DEF
) (
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] x1_clamped_o,
  output logic [COORD_W-1:0] y1_clamped_o,
  output logic               empty_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  assign x1_clamped_o = (x1_i > X_MAX) ? X_MAX : x1_i;
  assign y1_clamped_o = (y1_i > Y_MAX) ? Y_MAX : y1_i;
  assign empty_o      = (x0_i > x1_clamped_o) || (y0_i > y1_clamped_o);

endmodule

// File: rtl/rect_fill.sv
// Raster fill engine: walks a clipped rectangle row-major, one pixel per handshake.
// Optional checkerboard colouring is enabled by defining RECT_FILL_PATTERN_EN.
module rect_fill
  import gfx_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int COLOR_W = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] fill_color,
`ifdef RECT_FILL_PATTERN_EN
  input  logic               pattern_en,
`endif
  input  logic               ready,
  output logic               valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  fill_state_t        state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COLOR_W-1:0] fill_q, fill_d, color_q, color_d, c_base;
  logic               valid_q, valid_d, done_q, done_d, load_pix;
  logic [COORD_W-1:0] x1_clip, y1_clip;
  logic               clip_empty;
`ifdef RECT_FILL_PATTERN_EN
  logic               pat_q, pat_d, pat_sel;
`endif

  rect_clip #(.H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W)) u_clip (
    .x0_i        (x0),
    .y0_i        (y0),
    .x1_i        (x1),
    .y1_i        (y1),
    .x1_clamped_o(x1_clip),
    .y1_clamped_o(y1_clip),
    .empty_o     (clip_empty)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    load_pix = 1'b0;
    c_base   = fill_q;
`ifdef RECT_FILL_PATTERN_EN
    pat_d    = pat_q;
    pat_sel  = pat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d   = x0;
          x1_d   = x1_clip;
          y1_d   = y1_clip;
          fill_d = fill_color;
`ifdef RECT_FILL_PATTERN_EN
          pat_d   = pattern_en;
          pat_sel = pattern_en;
`endif
          if (clip_empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = FILL;
            valid_d  = 1'b1;
            x_d      = x0;
            y_d      = y0;
            load_pix = 1'b1;
            c_base   = fill_color;
          end
        end
      end
      FILL: begin
        // Abort wins over a same-cycle handshake, so no done pulse follows.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (ready) begin
          if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_d      = x0_q;
              y_d      = y_q + COORD_W'(1);
              load_pix = 1'b1;
            end
          end else begin
            x_d      = x_q + COORD_W'(1);
            load_pix = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_pix) begin
`ifdef RECT_FILL_PATTERN_EN
      color_d = (pat_sel && (x_d[0] ^ y_d[0])) ? ~c_base : c_base;
`else
      color_d = c_base;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      fill_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef RECT_FILL_PATTERN_EN
      pat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      fill_q  <= fill_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef RECT_FILL_PATTERN_EN
      pat_q   <= pat_d;
`endif
    end
  end

  assign valid = valid_q;
  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill on a reduced 64x48 screen.
// Expected pixel streams come from a rectangle-walking model with on-screen clipping.
module tb_rect_fill;

  localparam int H  = 64;
  localparam int V  = 48;
  localparam int CW = 11;
  localparam int KW = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort, ready;
  logic [CW-1:0] x0, y0, x1, y1;
  logic [KW-1:0] fill_color;
`ifdef RECT_FILL_PATTERN_EN
  logic          pattern_en;
`endif
  logic          valid, busy, done;
  logic [CW-1:0] x, y;
  logic [KW-1:0] color;

  int checks   = 0;
  int failures = 0;

  typedef struct {int px; int py; int pc;} pix_t;
  pix_t exp_q[$];

  always #5 clk = ~clk;

  rect_fill #(.H_RES(H), .V_RES(V), .COORD_W(CW), .COLOR_W(KW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .fill_color(fill_color),
`ifdef RECT_FILL_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .ready     (ready),
    .valid     (valid),
    .x         (x),
    .y         (y),
    .color     (color),
    .busy      (busy),
    .done      (done)
  );

  task automatic set_pat(input bit p);
`ifdef RECT_FILL_PATTERN_EN
    pattern_en = p;
`endif
  endtask

  // Reference: every on-screen pixel of the rectangle, row by row.
  function automatic void build(input int ax0, ay0, ax1, ay1, c, input bit pat);
    int cx1, cy1, col;
    exp_q.delete();
    cx1 = (ax1 > H - 1) ? H - 1 : ax1;
    cy1 = (ay1 > V - 1) ? V - 1 : ay1;
    for (int yy = ay0; yy <= cy1; yy++)
      for (int xx = ax0; xx <= cx1; xx++) begin
        col = (pat && ((xx + yy) % 2 == 1)) ? ((~c) & ((1 << KW) - 1)) : c;
        exp_q.push_back('{xx, yy, col});
      end
  endfunction

  task automatic fail(input string what, input int got, input int want);
    failures++;
    $display("FAIL %s: got %0d expected %0d", what, got, want);
  endtask

  // mode: 0 ready always high, 1 ready every other cycle, 2 random ready.
  task automatic run_fill(input int ax0, ay0, ax1, ay1, c, input bit pat, input int mode,
                          input bit noise, input int abort_after);
    bit finished = 0;
    bit stall = 0;
    int hx = 0, hy = 0, hc = 0, n = 0;
    pix_t p;
    build(ax0, ay0, ax1, ay1, c, pat);
    @(negedge clk);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    fill_color = KW'(c); set_pat(pat); ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) fail("start_busy", int'(busy), 1);
    if (exp_q.size() == 0) begin
      checks++; if (done !== 1'b1) fail("empty_done", int'(done), 1);
      checks++; if (valid !== 1'b0) fail("empty_valid", int'(valid), 0);
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) fail("empty_release", int'({done, busy}), 0);
      return;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      if (noise) begin
        x0 = CW'($urandom_range(0, 100)); y0 = CW'($urandom_range(0, 60));
        x1 = CW'($urandom_range(0, 100)); y1 = CW'($urandom_range(0, 60));
        fill_color = KW'($urandom); start = 1'($urandom_range(0, 1));
      end
      checks++; if (valid !== 1'b1 || done !== 1'b0) fail("valid_hold", int'({valid, done}), 2);
      if (stall) begin
        checks++;
        if (x !== CW'(hx) || y !== CW'(hy) || color !== KW'(hc)) fail("stall_stable_x", int'(x), hx);
      end
      if (abort_after >= 0 && n == abort_after) begin
        abort = 1'b1; ready = 1'b1; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (valid !== 1'b0) fail("abort_valid", int'(valid), 0);
        checks++; if (busy !== 1'b0) fail("abort_busy", int'(busy), 0);
        checks++; if (done !== 1'b0) fail("abort_done", int'(done), 0);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) fail("abort_quiet", int'({done, busy}), 0);
        return;
      end
      if (ready) begin
        p = exp_q.pop_front();
        n++;
        stall = 0;
        checks++; if (x !== CW'(p.px)) fail("pix_x", int'(x), p.px);
        checks++; if (y !== CW'(p.py)) fail("pix_y", int'(y), p.py);
        checks++; if (color !== KW'(p.pc)) fail("pix_color", int'(color), p.pc);
        if (exp_q.size() == 0) begin
          start = 1'b0;
          @(negedge clk);
          ready = 1'b0;
          checks++; if (done !== 1'b1) fail("last_done", int'(done), 1);
          checks++; if (busy !== 1'b1) fail("last_busy", int'(busy), 1);
          checks++; if (valid !== 1'b0) fail("last_valid", int'(valid), 0);
          @(negedge clk);
          checks++; if (done !== 1'b0 || busy !== 1'b0) fail("after_done", int'({done, busy}), 0);
          finished = 1;
          break;
        end
      end else begin
        stall = 1; hx = int'(x); hy = int'(y); hc = int'(color);
      end
      @(negedge clk);
    end
    if (!finished) fail("fill_timeout", exp_q.size(), 0);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({valid, busy, done, x, y, color} !== '0) fail("reset_outputs", int'({valid, busy, done}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) fail("reset_release", int'({busy, valid}), 0);
  endtask

  task automatic test_full_clear();
    run_fill(0, 0, H - 1, V - 1, 0, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_small_rect_stall();
    run_fill(10, 5, 12, 6, 1, 1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_empty();
    run_fill(70, 0, 90, 3, 1, 1'b0, 0, 1'b0, -1);
    run_fill(5, 10, 20, 9, 0, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_clamp();
    run_fill(60, 45, 200, 300, 1, 1'b0, 2, 1'b0, -1);
  endtask

  task automatic test_abort();
    run_fill(0, 0, H - 1, V - 1, 1, 1'b0, 0, 1'b0, 50);
    run_fill(3, 4, 5, 5, 1, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_random_ignore_start();
    for (int i = 0; i < 8; i++) begin
      int ax0, ay0;
      ax0 = $urandom_range(0, 70);
      ay0 = $urandom_range(0, 50);
      run_fill(ax0, ay0, $urandom_range(0, 80), ay0 + $urandom_range(0, 5),
               $urandom_range(0, 1), 1'b0, 2, 1'b1, -1);
    end
  endtask

  task automatic test_async_reset();
    build(0, 0, H - 1, V - 1, 1, 1'b0);
    @(negedge clk);
    x0 = '0; y0 = '0; x1 = CW'(H - 1); y1 = CW'(V - 1); fill_color = 1'b1; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, done, x, y, color} !== '0) fail("async_reset_outputs", int'({valid, busy, done}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) fail("post_reset_quiet", int'({done, busy, valid}), 0);
    end
    run_fill(7, 2, 9, 3, 0, 1'b0, 0, 1'b0, -1);
  endtask

`ifdef RECT_FILL_PATTERN_EN
  task automatic test_pattern();
    run_fill(0, 0, 1, 1, 1, 1'b1, 0, 1'b0, -1);
    run_fill(3, 7, 9, 10, 0, 1'b1, 2, 1'b0, -1);
  endtask
`endif

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; fill_color = '0;
    set_pat(1'b0);
    test_reset();
    test_full_clear();
    test_small_rect_stall();
    test_empty();
    test_clamp();
    test_abort();
    test_random_ignore_start();
    test_async_reset();
`ifdef RECT_FILL_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_fill.md
# rect_fill

Parametrised raster fill engine, the successor to the fixed 640x480 screen clear. It walks every pixel of a programmable rectangle, or the full screen, and emits one (x, y, color) write per accepted handshake to the framebuffer writer. Supported fills are solid colour and, optionally, a checkerboard pattern. The block sits between the game-state controller, which issues fill commands, and the VGA framebuffer write port, which applies backpressure.

## Interface
Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- COORD_W, 11, width of every coordinate port; must satisfy 2^COORD_W > max(H_RES, V_RES)
- COLOR_W, 1, pixel colour width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- abort  in  1  cancels the fill in progress
- x0, y0  in  COORD_W  rectangle top-left corner, inclusive
- x1, y1  in  COORD_W  rectangle bottom-right corner, inclusive
- fill_color  in  COLOR_W  fill colour
- pattern_en  in  1  checkerboard select; present only with RECT_FILL_PATTERN_EN
- ready  in  1  downstream accepts the current pixel
- valid  out  1  x/y/color hold a pixel to write
- x, y  out  COORD_W  pixel coordinate
- color  out  COLOR_W  pixel colour
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States and transitions:
  - IDLE -> FILL on start.
  - FILL -> DONE on the handshake of the last pixel.
  - FILL -> IDLE on abort.
  - DONE -> IDLE unconditionally after one cycle.
- Command latch:
  - On start in IDLE, x0/y0/x1/y1/fill_color (and pattern_en) are registered internally.
  - Inputs may change freely afterwards.
- Clipping:
  - Latched x1 is clamped to H_RES-1; latched y1 is clamped to V_RES-1.
  - If x0 > clamped x1, or y0 > clamped y1, the rectangle is empty: go IDLE -> DONE directly with valid never asserted.
- Scan order:
  - Row-major: x increments from x0 to x1.
  - At x1, x wraps to x0 and y increments.
  - The last pixel is (x1, y1).
- Pixel count is exactly (x1-x0+1)*(y1-y0+1).
- Full-screen clear: x0=y0=0, x1=H_RES-1, y1=V_RES-1.
- Handshake rules:
  - A pixel transfers on a cycle where valid && ready.
  - While valid && !ready, x, y and color hold stable.
  - valid never drops without a transfer, except on abort or reset.
- Solid mode: color = latched fill_color.
- Arithmetic:
  - Counters are COORD_W bits.
  - The comparison x == x1 drives the wrap, so no counter ever exceeds x1 or y1.
  - Overflow is impossible given the COORD_W constraint.
- Simultaneous events:
  - start in FILL or DONE is ignored.
  - abort overrides a same-cycle handshake: the pixel counts as written, but done is not pulsed.
  - abort in IDLE or DONE has no effect.
- Reset values: valid=0, busy=0, done=0, x=0, y=0, color=0, state IDLE.
- Reset asserted mid-fill discards the command with no done pulse.

## Timing
- Start registered at edge N: busy=1 and valid=1 with (x0,y0) after edge N.
- Throughput is one pixel per cycle while ready is held high; full 640x480 takes 307200 cycles plus overhead.
- Last handshake at edge M: done=1 and busy=1 (DONE state) after M, valid=0.
- After edge M+1: busy=0 and the block accepts a new start.
- Empty rectangle: done pulses in the cycle after start is accepted.
- Abort at edge A: valid=0 and busy=0 after A.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: RECT_FILL_PATTERN_EN.
- Defined:
  - The pattern_en port exists and is latched with the command.
  - When the latched value is 1: color = ((x ^ y) & 1) ? ~fill_color : fill_color, evaluated for the pixel being presented.
- Undefined:
  - The port is absent and solid mode is the only mode.
  - The pattern logic is not synthesised.

## Structure
- Shared package gfx_pkg:
  - COORD_W default.
  - Default H_RES/V_RES constants.
  - coord_t typedef.
  - fill_state_t enum (IDLE, FILL, DONE).
- Sub-module rect_clip:
  - Combinational.
  - Takes raw corners plus H_RES/V_RES.
  - Returns clamped x1/y1 and an empty flag.
  - Instantiated once, ahead of the command registers.

## Test plan
- Full-screen clear, ready=1, fill_color=0: exactly 307200 transfers, first (0,0), last (639,479); done one cycle after the last transfer.
- Rect (10,5)-(12,6), ready toggling every other cycle: 6 transfers in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); outputs stable during stalls.
- Rect (700,0)-(900,3): x0 exceeds clamped x1=639, so empty: valid never rises and done pulses the cycle after start.
- Abort after 50 transfers of a full clear: valid=0 and busy=0 next cycle with no done; a new start then begins at its own x0,y0.
- reset_n pulled low mid-fill and asynchronously (between edges): all outputs go to reset values immediately; start during FILL is ignored (latched corners unchanged).
- With RECT_FILL_PATTERN_EN, pattern_en=1, COLOR_W=1, fill_color=1, rect (0,0)-(1,1): colors 1,0,0,1.
